// File: rtl/state_loader_if.sv
// Host byte bus feeding the state loader.
// Handshake: the master holds in_byte stable while in_valid is high; a byte
// transfers on every rising clk edge where in_valid && in_ready are both 1.
interface state_loader_if;
  logic [7:0] in_byte;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_byte, output in_valid, input in_ready);
  modport slave  (input in_byte, input in_valid, output in_ready);
endinterface

// File: rtl/state_loader.sv
// Framed byte-stream deserializer that rebuilds cracker state and publishes it
// only once the trailing XOR checksum matches.
module state_loader #(
  parameter int         NUM_HASHES = 128,
  parameter int         MAX_PW_LEN = 20,
  parameter logic [7:0] MAGIC      = 8'hA5
) (
  input  logic                      clk,
  input  logic                      reset,
  state_loader_if.slave             bus,
  input  logic                      clear_error,
  output logic [4:0]                password_len,
  output logic [8*MAX_PW_LEN-1:0]   password_chars,
  output logic [128*NUM_HASHES-1:0] hashes,
  output logic [127:0]              md4_hash_holder,
  output logic                      state_valid,
  output logic                      load_done,
  output logic                      load_error,
  output logic [2:0]                state_dbg
);

  localparam int HB = NUM_HASHES * 16;
  // Counter also indexes password bytes, which can need 5 bits on small tables.
  localparam int CW = ($clog2(HB) > 5) ? $clog2(HB) : 5;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_CHARS, S_HASHES, S_MD4, S_CSUM, S_ERROR
  } state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt;
  logic [7:0]      csum;
  logic            accept;
  logic            len_bad;

  assign bus.in_ready = (state != S_ERROR);
  assign load_error   = (state == S_ERROR);
  assign accept       = bus.in_valid && (state != S_ERROR);
  assign len_bad      = (bus.in_byte > 8'(MAX_PW_LEN));
  assign state_dbg    = state;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (accept && bus.in_byte == MAGIC) state_next = S_LEN;
      S_LEN:    if (accept) state_next = len_bad ? S_ERROR : S_CHARS;
      S_CHARS:  if (accept && cnt == CW'(MAX_PW_LEN - 1)) state_next = S_HASHES;
      S_HASHES: if (accept && cnt == CW'(HB - 1)) state_next = S_MD4;
      S_MD4:    if (accept && cnt == CW'(15)) state_next = S_CSUM;
      S_CSUM:   if (accept) state_next = (bus.in_byte == csum) ? S_IDLE : S_ERROR;
      S_ERROR:  if (clear_error) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt             <= '0;
      csum            <= '0;
      password_len    <= '0;
      password_chars  <= '0;
      hashes          <= '0;
      md4_hash_holder <= '0;
      state_valid     <= 1'b0;
      load_done       <= 1'b0;
    end else begin
      load_done <= 1'b0;
      if (state_next == S_ERROR) state_valid <= 1'b0;
      if (accept) begin
        cnt <= (state_next != state) ? '0 : cnt + CW'(1);
        case (state)
          S_IDLE: if (bus.in_byte == MAGIC) csum <= '0;
          S_LEN: begin
            if (!len_bad) begin
              password_len <= bus.in_byte[4:0];
              state_valid  <= 1'b0;
              csum         <= csum ^ bus.in_byte;
            end
          end
          S_CHARS: begin
            for (int i = 0; i < MAX_PW_LEN; i++)
              if (cnt == CW'(i)) password_chars[8*i +: 8] <= bus.in_byte;
            csum <= csum ^ bus.in_byte;
          end
          S_HASHES: begin
            for (int i = 0; i < HB; i++)
              if (cnt == CW'(i)) hashes[8*i +: 8] <= bus.in_byte;
            csum <= csum ^ bus.in_byte;
          end
          S_MD4: begin
            for (int i = 0; i < 16; i++)
              if (cnt == CW'(i)) md4_hash_holder[8*i +: 8] <= bus.in_byte;
            csum <= csum ^ bus.in_byte;
          end
          S_CSUM: begin
            if (bus.in_byte == csum) begin
              state_valid <= 1'b1;
              load_done   <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/state_loader.md
Name: state_loader

Overview:
- Byte-stream deserializer that restores cracker state. It is the inbound counterpart of the state giver, which streams state out byte by byte.
- A host pushes a framed byte stream over a valid/ready handshake. The block rebuilds password length, password characters, target hash table and MD4 holder, and publishes them only after the frame checksum verifies.
- Sits between the host byte bus and the cracker's state-restore inputs, in the same clock domain as the cracker.

Parameters:
- NUM_HASHES, 128, number of 128-bit target hashes in the table (1..128)
- MAX_PW_LEN, 20, number of password character bytes carried in a frame (1..31)
- MAGIC, 8'hA5, frame start byte

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- in_byte  input  8  incoming stream byte
- in_valid  input  1  in_byte is valid this cycle
- in_ready  output  1  block can accept a byte; a transfer occurs when in_valid && in_ready at a rising clk edge
- clear_error  input  1  leaves ERROR state
- password_len  output  5  restored password length
- password_chars  output  8*MAX_PW_LEN  restored characters; char i at bits [8i+7:8i]
- hashes  output  128*NUM_HASHES  restored hashes; hash h byte b at bits [128h+8b+7 : 128h+8b]
- md4_hash_holder  output  128  restored MD4 holder; byte b at bits [8b+7:8b]
- state_valid  output  1  outputs hold a verified frame
- load_done  output  1  one-cycle pulse when a frame commits
- load_error  output  1  sticky error flag while in ERROR

Behaviour:
- Reset: state IDLE; all data outputs 0; state_valid=0; load_done=0; load_error=0; in_ready=1; byte counter=0; checksum=0. Reset mid-frame discards the partial frame.
- Frame order:
  - MAGIC
  - LEN byte
  - MAX_PW_LEN char bytes
  - NUM_HASHES*16 hash bytes, hash 0 byte 0 first, byte index fastest
  - 16 MD4 bytes, byte 0 first
  - CSUM byte = XOR of every byte from LEN through last MD4 byte (MAGIC excluded)
- FSM states: IDLE, LEN, CHARS, HASHES, MD4, CSUM, ERROR. in_ready=1 in all states except ERROR. Transitions happen only on accepted bytes, except ERROR exit.
- IDLE:
  - Accepted byte == MAGIC -> LEN, checksum cleared.
  - Other bytes are silently dropped, with no error.
- LEN:
  - If byte > MAX_PW_LEN -> ERROR.
  - Else write password_len = byte[4:0], clear state_valid, XOR byte into checksum -> CHARS.
- CHARS, HASHES, MD4:
  - Each accepted byte is written directly into its output field at the current counter index and XORed into checksum.
  - Counter ($clog2(NUM_HASHES*16) bits minimum) resets to 0 on each state change.
  - State advances on the last byte of the field (index MAX_PW_LEN-1, NUM_HASHES*16-1, 15 respectively).
- CSUM:
  - Byte == checksum -> IDLE, state_valid=1, load_done=1 for exactly one cycle (the cycle after the CSUM transfer edge).
  - Mismatch -> ERROR.
- ERROR:
  - load_error=1, state_valid=0, in_ready=0.
  - clear_error=1 -> IDLE next cycle, load_error=0.
  - Data outputs keep the partially written contents and are not trusted while state_valid=0.
- Latency: a field write is visible the cycle after its transfer edge. Commit occurs one cycle after the CSUM byte is accepted.
- in_valid=0 cycles stall the FSM with no state change. Gaps between bytes are unlimited.
- clear_error outside ERROR has no effect. reset wins over every other input.
- A MAGIC value appearing inside the payload is treated as data; there is no resync mid-frame.
- A new frame starting while state_valid=1 clears state_valid on its LEN byte.

Test Plan:
- Reset -> in_ready=1, state_valid=0, all outputs 0.
- Good frame with NUM_HASHES=2, MAX_PW_LEN=20: A5, LEN 04, chars 'a','b','c','d',16×00, hash bytes 00..1F, md4 bytes F0..FF, correct XOR -> password_len=4, password_chars[31:0]=64636261, hashes[7:0]=00, hashes[255:248]=1F, md4_hash_holder[127:120]=FF, one load_done pulse, state_valid=1.
- Same frame with the checksum byte XOR 01 -> load_error=1, in_ready=0, state_valid=0. Pulse clear_error -> IDLE, in_ready=1, load_error=0.
- Garbage 00 13 FF before A5, then a good frame -> garbage ignored, frame commits normally.
- LEN=21 -> immediate ERROR, no further bytes accepted.
- Good frame with random in_valid gaps, and reset asserted halfway through a second frame -> first frame commits correctly; after reset all outputs are 0 and state_valid=0.
